// File: rtl/text_letter_encoder.sv
// ASCII string -> 5-bit letter code encoder feeding the overlay letter BRAM and the text renderer.
// Optional LOWERCASE_FOLD_EN: fold 'a'..'z' onto the same codes as 'A'..'Z'.
module text_letter_map (
  input  logic [7:0] ascii_i,
  output logic [4:0] code_o
);
  always_comb begin
    code_o = 5'd26;
    if (ascii_i >= 8'h41 && ascii_i <= 8'h5A) code_o = 5'(ascii_i - 8'h41);
`ifdef LOWERCASE_FOLD_EN
    else if (ascii_i >= 8'h61 && ascii_i <= 8'h7A) code_o = 5'(ascii_i - 8'h61);
`else
    else code_o = 5'd26;
`endif
  end
endmodule

module text_letter_encoder #(
  parameter int TEXT_LEN_MAX = 20,
  parameter int ADDR_W       = 5,
  parameter int BASE_ADDR    = 0
) (
  input  logic                      clock_27mhz,
  input  logic                      reset_n,
  input  logic [TEXT_LEN_MAX*8-1:0] char_array,
  input  logic                      char_array_rdy,
  input  logic [5:0]                num_char,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [4:0]                wr_data,
  input  logic                      wr_ready,
  output logic [TEXT_LEN_MAX*5-1:0] letter_array,
  output logic [5:0]                letter_count,
  output logic                      busy,
  output logic                      done
);
  localparam int CW = 6;
  localparam int SW = (TEXT_LEN_MAX > 1) ? $clog2(TEXT_LEN_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_PAD, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic                           rdy_q;
  logic [TEXT_LEN_MAX-1:0][7:0]   chars_q, chars_d;
  logic [CW-1:0]                  cnt_q, cnt_d, idx_q, idx_d;
  logic                           wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]              wr_addr_q, wr_addr_d;
  logic [4:0]                     wr_data_q, wr_data_d;
  logic [TEXT_LEN_MAX-1:0][4:0]   letter_q, letter_d;
  logic                           busy_q, busy_d, done_q, done_d;

  // Element g of the packed arrays holds typed position TEXT_LEN_MAX-1-g.
  logic [TEXT_LEN_MAX-1:0][4:0]   code_w;

  for (genvar g = 0; g < TEXT_LEN_MAX; g++) begin : g_map
    text_letter_map u_map (.ascii_i(chars_q[g]), .code_o(code_w[g]));
  end

  logic          rise, accept;
  logic [CW-1:0] idx_nxt;
  logic [SW-1:0] pos_cur, pos_nxt;
  logic [4:0]    code_cur, code_nxt;

  assign rise     = char_array_rdy && !rdy_q;
  assign accept   = wr_en_q && wr_ready;
  assign idx_nxt  = idx_q + CW'(1);
  assign pos_cur  = SW'(TEXT_LEN_MAX-1) - SW'(idx_q);
  assign pos_nxt  = SW'(TEXT_LEN_MAX-1) - SW'(idx_nxt);
  // Slots at or beyond the clamped count are padded with blanks.
  assign code_cur = (idx_q   < cnt_q) ? code_w[pos_cur] : 5'd26;
  assign code_nxt = (idx_nxt < cnt_q) ? code_w[pos_nxt] : 5'd26;

  always_comb begin
    state_d   = state_q;
    chars_d   = chars_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    letter_d  = letter_q;
    case (state_q)
      S_IDLE: begin
        wr_en_d = 1'b0;
        if (rise) begin
          chars_d  = char_array;
          cnt_d    = (num_char > CW'(TEXT_LEN_MAX)) ? CW'(TEXT_LEN_MAX) : num_char;
          idx_d    = '0;
          letter_d = {TEXT_LEN_MAX{5'd26}};
          state_d  = (cnt_d == '0) ? S_PAD : S_ENCODE;
        end
      end
      S_ENCODE, S_PAD: begin
        // A write accepted in the abort cycle still lands in letter_array.
        if (accept) begin
          letter_d[pos_cur] = wr_data_q;
          idx_d             = idx_nxt;
        end
        if (!char_array_rdy) begin
          state_d = S_IDLE;
          wr_en_d = 1'b0;
        end else if (!wr_en_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
          wr_data_d = code_cur;
        end else if (accept) begin
          if (idx_q == CW'(TEXT_LEN_MAX-1)) begin
            state_d = S_DONE;
            wr_en_d = 1'b0;
          end else begin
            wr_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_nxt);
            wr_data_d = code_nxt;
            state_d   = (idx_nxt >= cnt_q) ? S_PAD : S_ENCODE;
          end
        end
      end
      S_DONE: begin
        wr_en_d = 1'b0;
        if (!char_array_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ENCODE) || (state_d == S_PAD);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b0;
      chars_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= ADDR_W'(BASE_ADDR);
      wr_data_q <= 5'd26;
      letter_q  <= {TEXT_LEN_MAX{5'd26}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= char_array_rdy;
      chars_q   <= chars_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      letter_q  <= letter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign letter_array = letter_q;
  assign letter_count = cnt_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_text_letter_encoder.sv
// Bench for text_letter_encoder: table of strings with a write scoreboard, plus hand-written
// backpressure, abort and mid-string reset sequences.
module tb_text_letter_encoder;
  localparam int N  = 20;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N*8-1:0] char_array;
  logic           char_array_rdy;
  logic [5:0]     num_char;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [4:0]     wr_data;
  logic           wr_ready;
  logic [N*5-1:0] letter_array;
  logic [5:0]     letter_count;
  logic           busy, done;

  always #5 clk = ~clk;

  text_letter_encoder #(.TEXT_LEN_MAX(N), .ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clock_27mhz(clk), .reset_n(rst_n), .char_array(char_array), .char_array_rdy(char_array_rdy),
    .num_char(num_char), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .letter_array(letter_array), .letter_count(letter_count), .busy(busy), .done(done)
  );

  int n_chk = 0, n_pass = 0;

  typedef struct packed {logic [AW-1:0] addr; logic [4:0] data;} wr_t;
  wr_t sb[$];

  // ch: char k at [8k+:8]; codes: expected code k at [5k+:5] (slots >= 4 are blank)
  typedef struct {
    logic [31:0] ch;
    logic [5:0]  n;
    logic [5:0]  exp_cnt;
    logic [19:0] codes;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_en && wr_ready) begin : pop
      wr_t e;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: addr %0d data %0d with nothing expected", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 128'(wr_addr), 128'(e.addr));
        chk("wr_data", 128'(wr_data), 128'(e.data));
      end
    end
  end

  task automatic start_str(input vec_t v, output logic [N*5-1:0] exp_la);
    int cnt;
    cnt = (v.n > 6'(N)) ? N : int'(v.n);
    char_array = '0;
    for (int k = 0; k < 4; k++) char_array[8*(N-1-k) +: 8] = v.ch[8*k +: 8];
    exp_la = '0;
    for (int k = 0; k < N; k++) begin
      logic [4:0] c;
      c = (k < cnt && k < 4) ? v.codes[5*k +: 5] : 5'd26;
      sb.push_back('{AW'(k), c});
      exp_la[5*(N-1-k) +: 5] = c;
    end
    num_char = v.n;
    char_array_rdy = 1'b1;
  endtask

  task automatic wait_done(input string nm, output int span);
    int t, first;
    t = 0; first = -1;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
      if (wr_en && first < 0) first = t;
    end
    chk({nm, "_done"}, 128'(done), 128'(1));
    span = t - first;
  endtask

  task automatic drop_rdy(input string nm);
    @(posedge clk); #1 char_array_rdy = 1'b0;
    @(negedge clk); @(negedge clk);
    chk({nm, "_done_clear"}, 128'(done), 128'(0));
  endtask

  vec_t tbl[6];
  logic [N*5-1:0] exp_la;
  int span, acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0000_4948, 6'd2,  6'd2,  {5'd26, 5'd26, 5'd8,  5'd7}};   // "HI"
    tbl[1] = '{32'h0000_5A5A, 6'd0,  6'd0,  {5'd26, 5'd26, 5'd26, 5'd26}};  // count 0
    tbl[2] = '{32'h5B40_5A41, 6'd4,  6'd4,  {5'd26, 5'd26, 5'd25, 5'd0}};   // "AZ@["
`ifdef LOWERCASE_FOLD_EN
    tbl[3] = '{32'h0062_2061, 6'd3,  6'd3,  {5'd26, 5'd1,  5'd26, 5'd0}};   // "a b"
`else
    tbl[3] = '{32'h0062_2061, 6'd3,  6'd3,  {5'd26, 5'd26, 5'd26, 5'd26}};
`endif
    tbl[4] = '{32'h0000_5851, 6'd63, 6'd20, {5'd26, 5'd26, 5'd23, 5'd16}};  // "QX", clamp
    tbl[5] = '{32'h0000_7B60, 6'd2,  6'd2,  {5'd26, 5'd26, 5'd26, 5'd26}};  // "`{"

    char_array = '0; char_array_rdy = 1'b0; num_char = '0; wr_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 128'(wr_en), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr), 128'(0));
    chk("rst_wr_data", 128'(wr_data), 128'(26));
    chk("rst_letter_array", 128'(letter_array), 128'({N{5'd26}}));
    chk("rst_letter_count", 128'(letter_count), 128'(0));
    chk("rst_busy_done", 128'({busy, done}), 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 start_str(tbl[i], exp_la);
      wait_done($sformatf("vec%0d", i), span);
      chk($sformatf("vec%0d_write_span", i), 128'(span), 128'(20));
      chk($sformatf("vec%0d_letter_count", i), 128'(letter_count), 128'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_letter_array", i), 128'(letter_array), 128'(exp_la));
      chk($sformatf("vec%0d_busy", i), 128'(busy), 128'(0));
      chk($sformatf("vec%0d_sb_empty", i), 128'(sb.size()), 128'(0));
      drop_rdy($sformatf("vec%0d", i));
    end

    // Backpressure: "AB", sink stalls the first write for 3 cycles.
    wr_ready = 1'b0;
    @(posedge clk); #1 start_str('{32'h0000_4241, 6'd2, 6'd2, {5'd26, 5'd26, 5'd1, 5'd0}}, exp_la);
    acc = 0;
    while (!wr_en && acc < 50) begin @(negedge clk); acc++; end
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", 128'({wr_en, wr_addr, wr_data}), 128'({1'b1, 5'd0, 5'd0}));
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1 wr_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("bp_second", 128'({wr_en, wr_addr, wr_data}), 128'({1'b1, 5'd1, 5'd1}));
    wait_done("bp", span);
    chk("bp_letter_array", 128'(letter_array), 128'(exp_la));
    drop_rdy("bp");

    // Abort after 5 accepted writes of a 20-char string.
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) char_array[8*(N-1-k) +: 8] = 8'(8'h41 + k);
    num_char = 6'd20;
    for (int k = 0; k < 5; k++) sb.push_back('{AW'(k), 5'(k)});
    char_array_rdy = 1'b1;
    acc = 0;
    for (int t = 0; t < 100 && acc < 5; t++) begin
      @(negedge clk);
      if (wr_en && wr_ready) acc++;
    end
    chk("abort_accepts", 128'(acc), 128'(5));
    @(posedge clk); #1 char_array_rdy = 1'b0; wr_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("abort_idle", 128'({wr_en, busy, done}), 128'(0));
    exp_la = {N{5'd26}};
    for (int k = 0; k < 5; k++) exp_la[5*(N-1-k) +: 5] = 5'(k);
    chk("abort_letter_array", 128'(letter_array), 128'(exp_la));
    chk("abort_letter_count", 128'(letter_count), 128'(20));
    wr_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", 128'(done), 128'(0));

    // Reset mid-string: "HELLO", reset after 3 writes.
    @(posedge clk); #1;
    char_array = '0;
    char_array[8*(N-1) +: 8] = 8'h48; char_array[8*(N-2) +: 8] = 8'h45;
    char_array[8*(N-3) +: 8] = 8'h4C; char_array[8*(N-4) +: 8] = 8'h4C;
    char_array[8*(N-5) +: 8] = 8'h4F;
    num_char = 6'd5;
    sb.push_back('{AW'(0), 5'd7}); sb.push_back('{AW'(1), 5'd4}); sb.push_back('{AW'(2), 5'd11});
    char_array_rdy = 1'b1;
    acc = 0;
    for (int t = 0; t < 100 && acc < 3; t++) begin
      @(negedge clk);
      if (wr_en && wr_ready) acc++;
    end
    #1 rst_n = 1'b0; char_array_rdy = 1'b0;
    #1;
    chk("rst_mid_wr", 128'({wr_en, wr_addr, wr_data}), 128'({1'b0, 5'd0, 5'd26}));
    chk("rst_mid_letter_array", 128'(letter_array), 128'({N{5'd26}}));
    chk("rst_mid_status", 128'({letter_count, busy, done}), 128'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_mid_quiet", 128'({wr_en, busy, done}), 128'(0));
    chk("rst_mid_sb_empty", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
